// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer feeding one shared combinational 8-bit ALU.
// Grants one of two requesters, registers the ALU inputs, and holds a sanitised response until accepted.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result,
    output logic [3:0] rsp_flags,
    output logic [3:0] alu_sel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_su,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_p,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t state, state_next;
    logic   last_grant;
    logic   id_r;
    logic   grant0, grant1;

    // The ALU's S flag is sticky and its flags are stale below op 8, so S is rebuilt from the operands.
    function automatic logic [3:0] sanitise_flags(input logic [3:0] op, input logic [7:0] a,
                                                   input logic [7:0] b, input logic z,
                                                   input logic c, input logic p);
        logic s;
        s = ((op == 4'h9) || (op == 4'hB)) && (b > a);
        return op[3] ? {z, c, s, p} : 4'b0000;
    endfunction

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else if (req0_valid) begin
            grant0 = 1'b1;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) state_next = ISSUE;
            end
            ISSUE: state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_r       <= 1'b0;
            alu_sel    <= 4'h0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            rsp_result <= 8'h00;
            rsp_flags  <= 4'h0;
            rsp_id     <= 1'b0;
        end else begin
            state <= state_next;
            // Accept edge: latch the winner's payload into the ALU input registers.
            if ((state == IDLE) && (grant0 || grant1)) begin
                alu_sel    <= grant1 ? req1_op : req0_op;
                alu_a      <= grant1 ? req1_a  : req0_a;
                alu_b      <= grant1 ? req1_b  : req0_b;
                id_r       <= grant1;
                last_grant <= grant1;
            end
            // ALU outputs are only trusted here, while its inputs have been stable all cycle.
            if (state == ISSUE) begin
                rsp_result <= alu_su;
                rsp_flags  <= sanitise_flags(alu_sel, alu_a, alu_b, alu_z, alu_c, alu_p);
                rsp_id     <= id_r;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU model.
// Vector table for single transactions, plus sequences for fairness, backpressure and reset.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_op = 4'h0, req1_op = 4'h0;
    logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_id;
    logic [7:0] rsp_result;
    logic [3:0] rsp_flags;
    logic [3:0] alu_sel;
    logic [7:0] alu_a, alu_b, alu_su;
    logic       alu_z, alu_c, alu_p, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .alu_su(alu_su), .alu_z(alu_z), .alu_c(alu_c), .alu_p(alu_p),
        .busy(busy)
    );

    // ALU model: 8 add, 9 sub (C = no borrow), 7 shift-left, others xor; flags are junk below op 8.
    always_comb begin
        alu_c = 1'b0;
        case (alu_sel)
            4'h8: {alu_c, alu_su} = {1'b0, alu_a} + {1'b0, alu_b};
            4'h9: begin alu_su = alu_a - alu_b; alu_c = (alu_a >= alu_b); end
            4'h7: alu_su = alu_a << alu_b[2:0];
            default: alu_su = alu_a ^ alu_b;
        endcase
        alu_z = (alu_su == 8'h00);
        alu_p = ^alu_su;
        if (!alu_sel[3]) begin
            alu_z = 1'b1;
            alu_c = 1'b1;
            alu_p = 1'b1;
        end
    end

    typedef struct {
        logic       id;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] flags;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int n, input logic v, input logic [3:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        if (n == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        set_req(int'(v.id), 1'b1, v.op, v.a, v.b);
        #1;
        check({tag, " own_ready"}, v.id ? req1_ready : req0_ready, 1);
        check({tag, " other_ready"}, v.id ? req0_ready : req1_ready, 0);
        @(negedge clk);
        set_req(int'(v.id), 1'b0, v.op, v.a, v.b);
        #1;
        check({tag, " issue_busy"}, busy, 1);
        check({tag, " issue_rsp_valid"}, rsp_valid, 0);
        check({tag, " alu_inputs"}, {alu_sel, alu_a, alu_b}, {v.op, v.a, v.b});
        @(negedge clk);
        #1;
        check({tag, " rsp_valid"}, rsp_valid, 1);
        check({tag, " result"}, rsp_result, v.res);
        check({tag, " flags"}, rsp_flags, v.flags);
        check({tag, " id"}, rsp_id, v.id);
    endtask

    initial begin
        int acc_cyc[$];
        int rsp_ids[$];

        vecs[0] = '{1'b0, 4'h8, 8'h05, 8'h03, 8'h08, 4'b0001};
        vecs[1] = '{1'b1, 4'h9, 8'h03, 8'h05, 8'hFE, 4'b0011};
        vecs[2] = '{1'b1, 4'h8, 8'h01, 8'h01, 8'h02, 4'b0001};
        vecs[3] = '{1'b0, 4'h8, 8'hFF, 8'h01, 8'h00, 4'b1100};
        vecs[4] = '{1'b0, 4'h7, 8'h01, 8'h03, 8'h08, 4'b0000};
        vecs[5] = '{1'b1, 4'hB, 8'h02, 8'h07, 8'h05, 4'b0010};
        vecs[6] = '{1'b0, 4'h9, 8'h07, 8'h02, 8'h05, 4'b0100};
        vecs[7] = '{1'b1, 4'h9, 8'h05, 8'h05, 8'h00, 4'b1100};

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", {rsp_valid, rsp_id, rsp_result, rsp_flags, busy, req0_ready, req1_ready},
              '0);
        check("reset_alu", {alu_sel, alu_a, alu_b}, '0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
        @(negedge clk);
        #1;
        check("idle_after_rsp", busy, 0);
        check("alu_hold_idle", {alu_sel, alu_a, alu_b}, {4'h9, 8'h05, 8'h05});

        // Round-robin fairness from reset, both requesters always valid
        rst = 1'b1;
        #1;
        rst = 1'b0;
        @(negedge clk);
        set_req(0, 1'b1, 4'h8, 8'h01, 8'h02);
        set_req(1, 1'b1, 4'h8, 8'h03, 8'h04);
        for (int cyc = 0; cyc < 16; cyc++) begin
            #1;
            if (req0_ready && req1_ready) check("one_ready", 2, 1);
            if (req0_ready || req1_ready) acc_cyc.push_back(cyc);
            if (rsp_valid) rsp_ids.push_back(int'(rsp_id));
            @(negedge clk);
        end
        set_req(0, 1'b0, 4'h0, 8'h00, 8'h00);
        set_req(1, 1'b0, 4'h0, 8'h00, 8'h00);
        check("rr_rsp_count_ge4", rsp_ids.size() >= 4, 1);
        check("rr_acc_count_ge4", acc_cyc.size() >= 4, 1);
        if (rsp_ids.size() >= 4)
            check("rr_id_seq", {rsp_ids[0][0], rsp_ids[1][0], rsp_ids[2][0], rsp_ids[3][0]}, 4'b0101);
        if (acc_cyc.size() >= 4)
            for (int i = 1; i < 4; i++) check($sformatf("rr_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);
        repeat (3) @(negedge clk);

        // Backpressure: hold response for 5 cycles while both requesters wait
        rsp_ready = 1'b0;
        set_req(0, 1'b1, 4'h8, 8'h05, 8'h03);
        @(negedge clk);
        set_req(0, 1'b0, 4'h8, 8'h05, 8'h03);
        @(negedge clk);
        set_req(0, 1'b1, 4'h9, 8'h09, 8'h01);
        set_req(1, 1'b1, 4'h9, 8'h0A, 8'h02);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_hold%0d", i),
                  {rsp_valid, rsp_id, rsp_result, rsp_flags, alu_sel, alu_a, alu_b, req0_ready, req1_ready},
                  {1'b1, 1'b0, 8'h08, 4'b0001, 4'h8, 8'h05, 8'h03, 1'b0, 1'b0});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release_idle", {busy, rsp_valid}, 2'b00);
        check("bp_release_grant", {req0_ready, req1_ready}, 2'b01);
        set_req(0, 1'b0, 4'h0, 8'h00, 8'h00);
        set_req(1, 1'b0, 4'h0, 8'h00, 8'h00);

        // Reset during ISSUE (req0 was last granted, so without reset req1 would win a tie)
        @(negedge clk);
        set_req(0, 1'b1, 4'h8, 8'h11, 8'h22);
        @(negedge clk);
        set_req(0, 1'b0, 4'h8, 8'h11, 8'h22);
        #1;
        check("rst_issue_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_issue_now", {rsp_valid, busy}, 2'b00);
        rst = 1'b0;

        // Reset during RESP
        @(negedge clk);
        #1;
        check("rst_gap_idle", {busy, rsp_valid}, 2'b00);
        set_req(0, 1'b1, 4'h8, 8'h11, 8'h22);
        @(negedge clk);
        set_req(0, 1'b0, 4'h8, 8'h11, 8'h22);
        @(negedge clk);
        #1;
        check("rst_resp_pre_valid", rsp_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_resp_now", {rsp_valid, busy, rsp_result}, '0);
        rst = 1'b0;

        @(negedge clk);
        set_req(0, 1'b1, 4'h8, 8'h01, 8'h01);
        set_req(1, 1'b1, 4'h8, 8'h02, 8'h02);
        #1;
        check("rst_tie_grant", {req0_ready, req1_ready}, 2'b10);
        set_req(0, 1'b0, 4'h0, 8'h00, 8'h00);
        set_req(1, 1'b0, 4'h0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the shared 8-bit ALU. It accepts operation requests from two independent requesters over valid/ready handshakes and grants them round-robin. It drives the ALU's select and operand inputs from registers, then captures the ALU result and a sanitised flag set into a response register held until the consumer accepts it. It sits between the requesters and a single combinational ALU instance; the ALU's own outputs are only trusted on the cycle this block samples them.

## Interface
- No parameters. Widths are fixed at 8-bit data and 4-bit op to match the ALU.
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester n has an operation pending.
- req0_ready / req1_ready  out  1  requester n's operation accepted this cycle.
- req0_op / req1_op  in  4  ALU select code for requester n.
- req0_a / req1_a  in  8  operand A.
- req0_b / req1_b  in  8  operand B.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the response (0/1).
- rsp_result  out  8  ALU result.
- rsp_flags  out  4  {Z, C, S, P}.
- alu_sel  out  4  ALU select.
- alu_a, alu_b  out  8  ALU operands.
- alu_su  in  8  ALU result.
- alu_z, alu_c, alu_p  in  1  ALU zero, carry and parity flags.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM has three states: IDLE, ISSUE, RESP.
- **IDLE, grant:**
  - If exactly one req valid, that requester is granted.
  - If both are valid, the requester not in last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- **IDLE, accept:**
  - reqN_ready = (state==IDLE) && grantN, driven combinationally.
  - At most one ready is high in any cycle.
  - On the accepting edge, the block latches op, a and b into alu_sel, alu_a and alu_b.
  - On the same edge it records the requester in id_r and last_grant, and moves to ISSUE.
- **ISSUE:**
  - ALU inputs are stable from registers for the whole cycle.
  - On the closing edge the block captures rsp_result = alu_su and rsp_flags, and moves to RESP.
- **RESP:**
  - rsp_valid = 1.
  - On rsp_valid && rsp_ready the FSM returns to IDLE.
  - Otherwise it holds, with every output stable.
- **Flag rules:**
  - The ALU's S flag is sticky and its flags are stale for ops < 8, so the block computes flags itself as follows.
  - op[3]==0: rsp_flags = 4'b0000.
  - op[3]==1: Z = alu_z, C = alu_c, P = alu_p.
  - S is computed locally: S = (op==4'h9 || op==4'hB) && (b > a), unsigned. The ALU S input is not used.
- **Requester rules:**
  - Once valid is asserted, it stays high and the payload stays stable until ready.
  - The block does not check this rule.
  - No request is accepted while busy.
- **Reset values:**
  - state = IDLE, last_grant = 1, id_r = 0.
  - alu_sel = 0, alu_a = 0, alu_b = 0.
  - rsp_valid = 0, rsp_result = 0, rsp_flags = 0, rsp_id = 0.
  - busy = 0, both readys = 0.

## Timing
- Accept edge at T → ISSUE in cycle T+1 → rsp_valid high from cycle T+2.
- Request-to-response latency is 2 cycles.
- Peak throughput is 1 op per 3 cycles, with rsp_ready tied high.
- RESP with rsp_ready high goes to IDLE the next cycle. A new accept can happen in that IDLE cycle.
- alu_* outputs change only on accept edges and otherwise hold their last value, including in IDLE.
- rsp_result, rsp_flags and rsp_id change only on the ISSUE→RESP edge.
- **Reset mid-operation:** asserting rst in ISSUE or RESP forces IDLE and rsp_valid = 0 immediately, without waiting for a clock edge. The in-flight op is discarded with no response.
- **Simultaneous events:** a new request arriving in RESP is not accepted until IDLE, even if rsp_ready is high in the same cycle.

## Test plan
- Basic add: req0 op=8, A=05, B=03, rsp_ready=1.
  - req0_ready is high one cycle.
  - rsp_valid is high 2 cycles later with result 08, flags 0001, id 0.
- Subtract then add, checking that S is not sticky:
  - req1 op=9, A=03, B=05 → result FE, flags 0011.
  - Then op=8, A=01, B=01 → result 02, flags 0001.
- Add to zero: op=8, A=FF, B=01 → result 00, flags 1100.
- Op below 8: op=7, A=01, B=03 → result 08, flags 0000.
- Round-robin fairness:
  - Both valid continuously after reset.
  - rsp_id sequence is 0, 1, 0, 1.
  - Accepts are exactly 3 cycles apart.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid, result, flags, id and alu_* stay constant.
  - Both readys stay 0.
  - Release rsp_ready: IDLE on the next cycle.
- Reset mid-operation:
  - Assert rst during ISSUE and again during RESP.
  - rsp_valid drops immediately and busy = 0.
  - After release, the first accept goes to requester 0 on a tie.
